// File: rtl/instr_mem_decoder_pkg.sv
// Shared widths, defaults and helpers for the instruction-side decoder.
// Outstanding counters saturate at OUT_MAX to keep responses in order.
package instr_mem_decoder_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] ROM_BASE_DEF  = 32'h0004_0080;
    localparam int                ROM_DEPTH_DEF = 256;

    typedef logic [1:0] cnt_t;
    localparam cnt_t OUT_MAX = 2'd2;

    function automatic cnt_t cnt_next(cnt_t cnt, logic inc, logic dec);
        cnt_t res;
        unique case ({inc, dec})
            2'b10:   res = cnt + 2'd1;
            2'b01:   res = cnt - 2'd1;
            default: res = cnt;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/instr_mem_decoder_rom.sv
// Synchronous-read boot ROM; contents loaded externally via mem.
// Data register has no reset; validity is tracked by the decoder.
module instr_rom
    import instr_mem_decoder_pkg::*;
#(
    parameter int DEPTH = ROM_DEPTH_DEF,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              req_i,
    input  logic [IW-1:0]     addr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (req_i) begin
            rdata_o <= mem[addr_i];
        end
    end

endmodule

// File: rtl/instr_mem_decoder.sv
// Fetch-port decoder: boot ROM window vs external bus, in-order merge.
// A side stalls while the other still owes responses.
module instr_mem_decoder
    import instr_mem_decoder_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ROM_BASE  = ROM_BASE_DEF,
    parameter int                ROM_DEPTH = ROM_DEPTH_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              core_instr_req_i,
    output logic              core_instr_gnt_o,
    output logic              core_instr_rvalid_o,
    input  logic [ADDR_W-1:0] core_instr_addr_i,
    output logic [DATA_W-1:0] core_instr_rdata_o,
    output logic [DATA_W-1:0] core_instr_err_o,
    output logic              instr_req_o,
    input  logic              instr_gnt_i,
    input  logic              instr_rvalid_i,
    output logic [ADDR_W-1:0] instr_addr_o,
    input  logic [DATA_W-1:0] instr_rdata_i,
    input  logic [DATA_W-1:0] instr_err_i
);

    localparam int IW  = $clog2(ROM_DEPTH);
    localparam int AW1 = ADDR_W + 1;
    localparam logic [ADDR_W:0] ROM_LO = {1'b0, ROM_BASE};
    localparam logic [ADDR_W:0] ROM_HI = ROM_LO + AW1'(4 * ROM_DEPTH);

    cnt_t              rom_out;
    cnt_t              ext_out;
    logic              rom_vld;
    logic [DATA_W-1:0] last_rdata;
    logic              last_err;
    logic [DATA_W-1:0] rom_rdata;

    logic              hit_rom;
    logic [ADDR_W-1:0] offset;
    logic [IW-1:0]     idx;
    logic              stalled;
    logic              rom_gnt;
    logic              ext_gnt;
    logic              ext_rsp;
    logic              unused_bits;

    assign hit_rom = ({1'b0, core_instr_addr_i} >= ROM_LO)
                  && ({1'b0, core_instr_addr_i} < ROM_HI);
    assign offset  = core_instr_addr_i - ROM_BASE;
    assign idx     = offset[IW+1:2];

    // a response from an empty external side is spurious and dropped
    assign ext_rsp = instr_rvalid_i && (ext_out != '0);

    always_comb begin
        stalled = 1'b0;
        if (hit_rom) begin
            stalled = (ext_out != '0)
                   || ((rom_out == OUT_MAX) && !rom_vld);
        end else begin
            stalled = (rom_out != '0)
                   || ((ext_out == OUT_MAX) && !ext_rsp);
        end
    end

    assign rom_gnt          = core_instr_req_i && hit_rom && !stalled;
    assign instr_req_o      = core_instr_req_i && !hit_rom && !stalled;
    assign ext_gnt          = instr_req_o && instr_gnt_i;
    assign core_instr_gnt_o = rom_gnt || ext_gnt;
    assign instr_addr_o     = core_instr_addr_i;

    instr_rom #(
        .DEPTH (ROM_DEPTH)
    ) rom (
        .clk_i   (clk_i),
        .req_i   (rom_gnt),
        .addr_i  (idx),
        .rdata_o (rom_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rom_out    <= '0;
            ext_out    <= '0;
            rom_vld    <= 1'b0;
            last_rdata <= '0;
            last_err   <= 1'b0;
        end else begin
            rom_out <= cnt_next(rom_out, rom_gnt, rom_vld);
            ext_out <= cnt_next(ext_out, ext_gnt, ext_rsp);
            rom_vld <= rom_gnt;
            if (ext_rsp) begin
                last_rdata <= instr_rdata_i;
                last_err   <= instr_err_i[0];
            end else if (rom_vld) begin
                last_rdata <= rom_rdata;
                last_err   <= 1'b0;
            end
        end
    end

    assign core_instr_rvalid_o = rom_vld || ext_rsp;

    always_comb begin
        core_instr_rdata_o = last_rdata;
        core_instr_err_o   = {{(DATA_W-1){1'b0}}, last_err};
        if (ext_rsp) begin
            core_instr_rdata_o = instr_rdata_i;
            core_instr_err_o   = {{(DATA_W-1){1'b0}}, instr_err_i[0]};
        end else if (rom_vld) begin
            core_instr_rdata_o = rom_rdata;
            core_instr_err_o   = '0;
        end
    end

    assign unused_bits = ^{offset[ADDR_W-1:IW+2], offset[1:0],
                           instr_err_i[DATA_W-1:1]};

endmodule

// File: tb/tb_instr_mem_decoder.sv
// Scoreboard bench for instr_mem_decoder: ROM and external fetch paths.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_instr_mem_decoder;

    localparam logic [31:0] BASE = 32'h0004_0080;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        gnt;
    logic        rvalid;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] err;
    logic        ireq;
    logic        igGnt;
    logic        irvalid;
    logic [31:0] iaddr;
    logic [31:0] irdata;
    logic [31:0] ierr;

    int total = 0;
    int bad   = 0;

    logic [63:0] sb [$];

    always #5 clk = ~clk;

    instr_mem_decoder dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .core_instr_req_i    (req),
        .core_instr_gnt_o    (gnt),
        .core_instr_rvalid_o (rvalid),
        .core_instr_addr_i   (addr),
        .core_instr_rdata_o  (rdata),
        .core_instr_err_o    (err),
        .instr_req_o         (ireq),
        .instr_gnt_i         (igGnt),
        .instr_rvalid_i      (irvalid),
        .instr_addr_o        (iaddr),
        .instr_rdata_i       (irdata),
        .instr_err_i         (ierr)
    );

    // every core response must match the oldest expected one
    always @(negedge clk) begin
        if (rst_n && rvalid) begin
            logic [63:0] exp_v;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected got=%h/%h want=none",
                         rdata, err);
            end else begin
                exp_v = sb.pop_front();
                if ({rdata, err} !== exp_v) begin
                    bad++;
                    $display("FAIL rsp_data got=%h/%h want=%h/%h",
                             rdata, err, exp_v[63:32], exp_v[31:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req     = 1'b0;
        addr    = 32'h0;
        igGnt   = 1'b0;
        irvalid = 1'b0;
        irdata  = 32'h0;
        ierr    = 32'h0;
    endtask

    task automatic check_drained(string name);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_drain got=%0d want=0 pending", name, sb.size());
        end
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #12;
        total++;
        if ({rvalid, rdata, err, gnt, ireq} !== 67'h0) begin
            bad++;
            $display("FAIL reset_state got=%b/%h/%h/%b/%b want=0",
                     rvalid, rdata, err, gnt, ireq);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rom_stream();
        for (int k = 0; k < 32; k++) begin
            step();
            req  = 1'b1;
            addr = BASE + 32'(4 * k);
            @(negedge clk);
            total++;
            if (gnt !== 1'b1 || ireq !== 1'b0) begin
                bad++;
                $display("FAIL stream_gnt k=%0d got=%b/%b want=1/0",
                         k, gnt, ireq);
            end
            sb.push_back({32'h1000_0000 + 32'(k), 32'h0});
        end
        step();
        idle();
        step();
        check_drained("stream");
    endtask

    task automatic test_edges();
        logic [31:0] fwd [2];
        fwd[0] = 32'h0004_007C;
        fwd[1] = 32'h0004_0480;
        for (int i = 0; i < 2; i++) begin
            step();
            req  = 1'b1;
            addr = fwd[i];
            @(negedge clk);
            total++;
            if (ireq !== 1'b1 || iaddr !== fwd[i] || gnt !== 1'b0) begin
                bad++;
                $display("FAIL edge_fwd got=%b/%h/%b want=1/%h/0",
                         ireq, iaddr, gnt, fwd[i]);
            end
        end
        step();
        addr = 32'h0004_047C;
        @(negedge clk);
        total++;
        if (gnt !== 1'b1 || ireq !== 1'b0 || iaddr !== 32'h0004_047C) begin
            bad++;
            $display("FAIL edge_rom_last got=%b/%b want=1/0", gnt, ireq);
        end
        sb.push_back({32'h1000_00FF, 32'h0});
        step();
        idle();
        step();
        check_drained("edges");
    endtask

    task automatic test_ext();
        for (int c = 0; c < 3; c++) begin
            step();
            req   = 1'b1;
            addr  = 32'h0000_1000;
            igGnt = (c == 2);
            @(negedge clk);
            total++;
            if (gnt !== (c == 2) || ireq !== 1'b1) begin
                bad++;
                $display("FAIL ext_gnt c=%0d got=%b/%b want=%b/1",
                         c, gnt, ireq, c == 2);
            end
        end
        sb.push_back({32'hDEAD_BEEF, 32'h1});
        for (int c = 0; c < 3; c++) begin
            step();
            idle();
            if (c == 2) begin
                irvalid = 1'b1;
                irdata  = 32'hDEAD_BEEF;
                ierr    = 32'hFFFF_FFFF;
            end
            @(negedge clk);
            total++;
            if (rvalid !== (c == 2)) begin
                bad++;
                $display("FAIL ext_rvalid c=%0d got=%b want=%b",
                         c, rvalid, c == 2);
            end
        end
        step();
        idle();
        irdata = 32'h1234_5678;
        @(negedge clk);
        total++;
        if (rvalid !== 1'b0 || rdata !== 32'hDEAD_BEEF || err !== 32'h1) begin
            bad++;
            $display("FAIL ext_hold got=%b/%h/%h want=0/deadbeef/1",
                     rvalid, rdata, err);
        end
        step();
        irvalid = 1'b1;
        irdata  = 32'h5555_AAAA;
        @(negedge clk);
        total++;
        if (rvalid !== 1'b0) begin
            bad++;
            $display("FAIL ext_spurious got=%b want=0", rvalid);
        end
        step();
        idle();
        check_drained("ext");
    endtask

    task automatic test_switch();
        step();
        req   = 1'b1;
        addr  = 32'h0000_2000;
        igGnt = 1'b1;
        sb.push_back({32'h1111_2222, 32'h0});
        for (int c = 0; c < 4; c++) begin
            step();
            idle();
            req  = 1'b1;
            addr = BASE;
            if (c == 2) begin
                irvalid = 1'b1;
                irdata  = 32'h1111_2222;
            end
            @(negedge clk);
            total++;
            if (gnt !== (c == 3) || ireq !== 1'b0) begin
                bad++;
                $display("FAIL switch_gnt c=%0d got=%b/%b want=%b/0",
                         c, gnt, ireq, c == 3);
            end
        end
        sb.push_back({32'h1000_0000, 32'h0});
        step();
        idle();
        step();
        check_drained("switch");
    endtask

    task automatic test_limit();
        for (int c = 0; c < 4; c++) begin
            step();
            req   = 1'b1;
            addr  = 32'h0000_3000;
            igGnt = 1'b1;
            @(negedge clk);
            total++;
            if (gnt !== (c < 2) || ireq !== (c < 2)) begin
                bad++;
                $display("FAIL limit_stall c=%0d got=%b/%b want=%b/%b",
                         c, gnt, ireq, c < 2, c < 2);
            end
        end
        sb.push_back({32'hAAAA_0001, 32'h0});
        sb.push_back({32'hAAAA_0002, 32'h0});
        step();
        irvalid = 1'b1;
        irdata  = 32'hAAAA_0001;
        @(negedge clk);
        total++;
        if (gnt !== 1'b1 || ireq !== 1'b1) begin
            bad++;
            $display("FAIL limit_retire got=%b/%b want=1/1", gnt, ireq);
        end
        sb.push_back({32'hAAAA_0003, 32'h0});
        for (int c = 2; c <= 3; c++) begin
            step();
            idle();
            irvalid = 1'b1;
            irdata  = 32'hAAAA_0000 + 32'(c);
        end
        step();
        idle();
        step();
        check_drained("limit");
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 5; k++) begin
            step();
            req  = 1'b1;
            addr = BASE + 32'(4 * (k + 8));
            if (k < 4) begin
                sb.push_back({32'h1000_0008 + 32'(k), 32'h0});
            end
        end
        #2;
        total++;
        if (rvalid !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre got=%b want=1", rvalid);
        end
        rst_n = 1'b0;
        req   = 1'b0;
        #1;
        total++;
        if (rvalid !== 1'b0 || rdata !== 32'h0 || err !== 32'h0) begin
            bad++;
            $display("FAIL mid_async got=%b/%h/%h want=0/0/0",
                     rvalid, rdata, err);
        end
        sb.delete();
        step();
        #3;
        rst_n = 1'b1;
        step();
        req  = 1'b1;
        addr = BASE;
        @(negedge clk);
        total++;
        if (gnt !== 1'b1) begin
            bad++;
            $display("FAIL mid_regnt got=%b want=1", gnt);
        end
        sb.push_back({32'h1000_0000, 32'h0});
        step();
        idle();
        step();
        check_drained("mid");
    endtask

    initial begin
        for (int k = 0; k < 256; k++) begin
            dut.rom.mem[k] = 32'h1000_0000 + 32'(k);
        end
        test_reset();
        test_rom_stream();
        test_edges();
        test_ext();
        test_switch();
        test_limit();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_mem_decoder.md
Name: instr_mem_decoder

Overview:
Instruction-side address decoder between the core fetch port and the external instruction bus.
- Requests that hit the ROM window at ROM_BASE are served by an internal boot ROM.
- All other requests are forwarded unchanged to the external instruction port.
- Responses (rvalid/rdata/err) from both targets are merged back to the core in request order.

Parameters:
- ROM_BASE, 32'h00040080, byte base address of the ROM window; must be word aligned.
- ROM_DEPTH, 256, ROM size in 32-bit words; the window is [ROM_BASE, ROM_BASE + 4*ROM_DEPTH).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- core_instr_req_i  in  1  core fetch request.
- core_instr_gnt_o  out  1  request accepted this cycle.
- core_instr_rvalid_o  out  1  response valid.
- core_instr_addr_i  in  32  byte fetch address.
- core_instr_rdata_o  out  32  fetched instruction.
- core_instr_err_o  out  32  error; bit0 = error, bits 31:1 always 0.
- instr_req_o  out  1  external request.
- instr_gnt_i  in  1  external grant.
- instr_rvalid_i  in  1  external response valid.
- instr_addr_o  out  32  external address.
- instr_rdata_i  in  32  external read data.
- instr_err_i  in  32  external error; bit0 used.

Behaviour:
- Clocking and reset: one clock domain, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values: core_instr_rvalid_o=0, core_instr_rdata_o=0, core_instr_err_o=0, outstanding counters=0, ROM response register cleared. instr_req_o is combinational and therefore 0 whenever core_instr_req_i=0.
- Decode (combinational): hit_rom = (addr >= ROM_BASE) && (addr < ROM_BASE + 4*ROM_DEPTH).
  - ROM word index = (addr - ROM_BASE) >> 2; addr[1:0] ignored.
- ROM path:
  - core_instr_gnt_o = 1 in the same cycle as req when hit_rom and not stalled.
  - Exactly 1 cycle after gnt: core_instr_rvalid_o=1, rdata = mem[index], err=0.
  - Back-to-back requests give one word per cycle. No wait states.
- External path (~hit_rom):
  - instr_req_o = core_instr_req_i && !stalled.
  - instr_addr_o = core_instr_addr_i, passed through unchanged.
  - core_instr_gnt_o = instr_gnt_i && instr_req_o.
  - When instr_rvalid_i=1: core_instr_rvalid_o=1 in the same cycle, rdata = instr_rdata_i, err = {31'b0, instr_err_i[0]}.
- instr_addr_o always mirrors core_instr_addr_i, whichever target is selected.
- Ordering:
  - Two counters, rom_out and ext_out, each 0..2, count granted requests without a response yet.
  - stalled = 1 if the request targets one side while the other side's counter is non-zero. This guarantees in-order responses.
  - Also stalled if the selected side's counter is 2 and no response retires this cycle.
  - While stalled: gnt=0 and instr_req_o=0.
- Simultaneous gnt and response on the same side: the counter is unchanged.
- ROM and external responses never coincide, because of the stall rule.
- Spurious instr_rvalid_i with ext_out=0 is ignored: no core rvalid.
- rdata/err outside rvalid: hold last value.
- Reset mid-transaction: counters cleared; any pending ROM response is dropped.
- ROM contents: no reset. Loaded by simulation/synthesis init through hierarchical path rom.mem. The instance name must be rom and the array must be mem[ROM_DEPTH], 32-bit words.

Decomposition:
- Package instr_mem_decoder_pkg:
  - OBI signal widths (ADDR_W=32, DATA_W=32).
  - Default ROM_BASE and ROM_DEPTH.
  - Outstanding-count limit (2).
- One sub-module, instr_rom, instance name rom:
  - Synchronous-read ROM, array mem, port (clk_i, req_i, addr_i word index, rdata_o).
  - Registered rvalid lives in the decoder.

Test Plan:
- ROM streaming: mem preloaded with mem[k]=32'h1000_0000+k; req=1 from 0x00040080, addr +4 every cycle for 32 cycles -> gnt=1 every cycle; rvalid each following cycle with rdata 0x10000000..0x1000001F in order; instr_req_o=0 throughout.
- Window edges:
  - 0x0004007C -> forwarded: instr_req_o=1, instr_addr_o=0x0004007C.
  - 0x00040080 + 4*256 = 0x00040480 -> forwarded.
  - 0x0004047C -> ROM, mem[255].
- External path: addr 0x00001000, instr_gnt_i=1 after 2 cycles, rvalid_i with rdata 0xDEADBEEF and err 1 three cycles later -> core gnt only in the grant cycle; core rvalid same cycle with 0xDEADBEEF and err=32'h1.
- Target switch stall: external granted with no response yet, then request 0x00040080 -> gnt=0 until the external rvalid; ROM gnt in the cycle after the response, rvalid next cycle.
- Outstanding limit: two external grants without responses -> third request: instr_req_o=0 and gnt=0 until one rvalid_i arrives.
- Reset mid-stream: assert rst_ni=0 asynchronously between clock edges during ROM streaming -> rvalid, rdata and err drop to 0 immediately; after release, the first request at 0x00040080 returns mem[0].
